// File: rtl/robertsons_mult_param.sv
// ============================================================================
// robertsons_mult_param
//
// Sequential WIDTH x WIDTH -> 2*WIDTH multiplier using Robertson's add/shift
// method, retiring one multiplier bit per clock. Each operation selects
// signed (two's complement) or unsigned arithmetic. A start/busy/done
// handshake lets a controller issue operations back to back: a new start
// is accepted in the same cycle that done is high.
//
// Optional feature macro: ROBMUL_FIT_FLAG_EN
//   When defined, a 'fits' output reports whether the product is
//   representable in WIDTH bits in the selected mode.
//
// Ports
//   clk           in   1        rising-edge clock
//   reset         in   1        synchronous, active-high
//   start         in   1        request; sampled only when busy=0
//   signed_mode   in   1        1=signed, 0=unsigned; sampled with start
//   multiplier    in   WIDTH    operand Q; sampled with start
//   multiplicand  in   WIDTH    operand M; sampled with start
//   busy          out  1        high while iterating
//   done          out  1        one-cycle pulse; product valid
//   product       out  2*WIDTH  result, held until the next completion
//   fits          out  1        only with ROBMUL_FIT_FLAG_EN
// ============================================================================
module robertsons_mult_param #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic [WIDTH-1:0]     multiplicand,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
`ifdef ROBMUL_FIT_FLAG_EN
    ,
    output logic                 fits
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sgn_q, sgn_d;
    logic [2*WIDTH-1:0] product_q, product_d;
`ifdef ROBMUL_FIT_FLAG_EN
    logic               fits_q, fits_d;
`endif

    logic [WIDTH:0]     ext_m;
    logic [WIDTH:0]     a_sum;
    logic [WIDTH:0]     a_shift;
    logic [WIDTH-1:0]   q_shift;
    logic [2*WIDTH-1:0] new_product;
    logic               last_iter;

    // State and datapath registers; reset clears everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            q_q       <= '0;
            a_q       <= '0;
            cnt_q     <= '0;
            sgn_q     <= 1'b0;
            product_q <= '0;
`ifdef ROBMUL_FIT_FLAG_EN
            fits_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            q_q       <= q_d;
            a_q       <= a_d;
            cnt_q     <= cnt_d;
            sgn_q     <= sgn_d;
            product_q <= product_d;
`ifdef ROBMUL_FIT_FLAG_EN
            fits_q    <= fits_d;
`endif
        end
    end

    // Next-state logic. DONE behaves like IDLE for start so that a new
    // operation can be issued in the completion cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (last_iter) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // One Robertson iteration. The final step subtracts M in signed mode
    // because the multiplier MSB carries negative weight.
    always_comb begin
        ext_m     = sgn_q ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
        a_sum     = a_q;
        if (q_q[0]) begin
            a_sum = (last_iter && sgn_q) ? (a_q - ext_m) : (a_q + ext_m);
        end
        // Unsigned sums may carry into bit WIDTH, so a logical shift keeps it.
        a_shift     = {(sgn_q ? a_sum[WIDTH] : 1'b0), a_sum[WIDTH:1]};
        q_shift     = {a_sum[0], q_q[WIDTH-1:1]};
        new_product = {a_shift[WIDTH-1:0], q_shift};
    end

    // Datapath register updates: load operands on an accepted start,
    // iterate in RUN, capture the result on the last iteration.
    always_comb begin
        m_d       = m_q;
        q_d       = q_q;
        a_d       = a_q;
        cnt_d     = cnt_q;
        sgn_d     = sgn_q;
        product_d = product_q;
`ifdef ROBMUL_FIT_FLAG_EN
        fits_d    = fits_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    m_d   = multiplicand;
                    q_d   = multiplier;
                    sgn_d = signed_mode;
                    a_d   = '0;
                    cnt_d = '0;
                end
            end
            S_RUN: begin
                a_d   = a_shift;
                q_d   = q_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (last_iter) begin
                    product_d = new_product;
`ifdef ROBMUL_FIT_FLAG_EN
                    // Signed: upper half plus the lower MSB must be a pure
                    // sign extension. Unsigned: upper half must be zero.
                    if (sgn_q) begin
                        fits_d = (&new_product[2*WIDTH-1:WIDTH-1]) ||
                                 (~|new_product[2*WIDTH-1:WIDTH-1]);
                    end else begin
                        fits_d = ~|new_product[2*WIDTH-1:WIDTH];
                    end
`endif
                end
            end
            default: ;
        endcase
    end

    // Outputs are decoded directly from the state register.
    always_comb begin
        busy    = (state_q == S_RUN);
        done    = (state_q == S_DONE);
        product = product_q;
`ifdef ROBMUL_FIT_FLAG_EN
        fits    = fits_q;
`endif
    end

endmodule

// File: tb/tb_robertsons_mult_param.sv
// ============================================================================
// tb_robertsons_mult_param
//
// Self-checking bench for robertsons_mult_param. An 8-bit instance covers
// the handshake, latency, directed and random products; a 16-bit instance
// covers a wider configuration. Expected products come from plain integer
// multiplication of the operands interpreted in the selected mode.
// ============================================================================
module tb_robertsons_mult_param;

    logic        clk;
    logic        reset;
    logic        start;
    logic        signed_mode;
    logic [7:0]  multiplier;
    logic [7:0]  multiplicand;
    logic        busy;
    logic        done;
    logic [15:0] product;

    logic        start_w;
    logic        signed_mode_w;
    logic [15:0] multiplier_w;
    logic [15:0] multiplicand_w;
    logic        busy_w;
    logic        done_w;
    logic [31:0] product_w;

`ifdef ROBMUL_FIT_FLAG_EN
    logic        fits;
    logic        fits_w;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    robertsons_mult_param #(.WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .signed_mode  (signed_mode),
        .multiplier   (multiplier),
        .multiplicand (multiplicand),
        .busy         (busy),
        .done         (done),
        .product      (product)
`ifdef ROBMUL_FIT_FLAG_EN
        ,
        .fits         (fits)
`endif
    );

    robertsons_mult_param #(.WIDTH(16)) dut_w (
        .clk          (clk),
        .reset        (reset),
        .start        (start_w),
        .signed_mode  (signed_mode_w),
        .multiplier   (multiplier_w),
        .multiplicand (multiplicand_w),
        .busy         (busy_w),
        .done         (done_w),
        .product      (product_w)
`ifdef ROBMUL_FIT_FLAG_EN
        ,
        .fits         (fits_w)
`endif
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Mathematical product of two w-bit operands in the chosen mode.
    function automatic longint ref_value(input bit s, input longint q,
                                         input longint m, input int w);
        longint a;
        longint b;
        a = (s && q[w-1]) ? q - (longint'(1) << w) : q;
        b = (s && m[w-1]) ? m - (longint'(1) << w) : m;
        return a * b;
    endfunction

    // Whether a mathematical product is representable in w bits.
    function automatic bit ref_fits(input bit s, input longint p, input int w);
        if (s) return (p >= -(longint'(1) << (w - 1))) && (p < (longint'(1) << (w - 1)));
        return p < (longint'(1) << w);
    endfunction

    // Issue one 8-bit operation and wait for done. Operands are scrambled
    // right after the start edge to show the DUT latched them.
    task automatic run_op(input bit s, input logic [7:0] q, input logic [7:0] m,
                          output logic [15:0] p, output int lat,
                          output int busy_cycles, output bit timed_out);
        signed_mode  = s;
        multiplier   = q;
        multiplicand = m;
        start        = 1'b1;
        @(posedge clk); #1;
        start        = 1'b0;
        signed_mode  = 1'($urandom);
        multiplier   = 8'($urandom);
        multiplicand = 8'($urandom);
        lat          = 0;
        busy_cycles  = 0;
        while (!done && lat < 40) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        timed_out = !done;
        p = product;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    // Reset asserted together with start: reset wins and start is dropped.
    task automatic test_reset();
        int busy_seen;
        reset = 1'b1;
        start = 1'b1;
        signed_mode = 1'b1;
        multiplier = 8'h12;
        multiplicand = 8'h34;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        n_cmp++;
        if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        n_cmp++;
        if (product !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_product got=%h exp=0000", product); end
        n_cmp++;
        if (product_w !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_product_w got=%h exp=0", product_w); end
`ifdef ROBMUL_FIT_FLAG_EN
        n_cmp++;
        if (fits !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fits got=%b exp=0", fits); end
`endif
        busy_seen = 0;
        repeat (4) begin
            if (busy || done) busy_seen++;
            idle_cycle();
        end
        n_cmp++;
        if (busy_seen !== 0) begin n_fail++; $display("[TB] FAIL reset_start_discarded active_cycles=%0d exp=0", busy_seen); end
    endtask

    // Directed products, latency, busy length and one-cycle done.
    task automatic test_directed();
        logic [15:0] p;
        int lat, bc;
        bit to;
        logic [16:0] cases [9] = '{
            {1'b1, 8'h05, 8'h06}, {1'b1, 8'h07, 8'hFB}, {1'b1, 8'h80, 8'h80},
            {1'b1, 8'hF7, 8'hFC}, {1'b0, 8'hFF, 8'hFF}, {1'b0, 8'h80, 8'h02},
            {1'b1, 8'h80, 8'h02}, {1'b0, 8'h00, 8'hA5}, {1'b1, 8'h5A, 8'h00}};
        logic [15:0] exp_p [9] = '{16'h001E, 16'hFFDD, 16'h4000, 16'h0024,
                                   16'hFE01, 16'h0100, 16'hFF00, 16'h0000, 16'h0000};
        for (int i = 0; i < 9; i++) begin
            run_op(cases[i][16], cases[i][15:8], cases[i][7:0], p, lat, bc, to);
            n_cmp++;
            if (to) begin n_fail++; $display("[TB] FAIL directed_timeout case=%0d", i); end
            n_cmp++;
            if (p !== exp_p[i]) begin n_fail++; $display("[TB] FAIL directed_product case=%0d got=%h exp=%h", i, p, exp_p[i]); end
            n_cmp++;
            if (lat !== 8) begin n_fail++; $display("[TB] FAIL directed_latency case=%0d got=%0d exp=8", i, lat); end
            n_cmp++;
            if (bc !== 8) begin n_fail++; $display("[TB] FAIL directed_busy_len case=%0d got=%0d exp=8", i, bc); end
            idle_cycle();
            n_cmp++;
            if (done !== 1'b0) begin n_fail++; $display("[TB] FAIL directed_done_pulse case=%0d got=%b exp=0", i, done); end
            n_cmp++;
            if (product !== exp_p[i]) begin n_fail++; $display("[TB] FAIL directed_hold case=%0d got=%h exp=%h", i, product, exp_p[i]); end
        end
    endtask

`ifdef ROBMUL_FIT_FLAG_EN
    // Representability flag on the boundary operand pairs.
    task automatic test_fits();
        logic [15:0] p;
        int lat, bc;
        bit to;
        logic [16:0] cases [4] = '{{1'b1, 8'h80, 8'h01}, {1'b1, 8'h80, 8'h80},
                                   {1'b0, 8'd15, 8'd17}, {1'b0, 8'd16, 8'd16}};
        logic exp_f [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            run_op(cases[i][16], cases[i][15:8], cases[i][7:0], p, lat, bc, to);
            n_cmp++;
            if (fits !== exp_f[i]) begin n_fail++; $display("[TB] FAIL fits_flag case=%0d got=%b exp=%b", i, fits, exp_f[i]); end
            idle_cycle();
        end
    endtask
`endif

    // Random operands and modes against the arithmetic reference.
    task automatic test_random();
        logic [15:0] p;
        logic [15:0] exp_p;
        longint val;
        int lat, bc;
        bit to, s;
        logic [7:0] q, m;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom);
            q = 8'($urandom);
            m = 8'($urandom);
            val = ref_value(s, longint'(q), longint'(m), 8);
            exp_p = val[15:0];
            run_op(s, q, m, p, lat, bc, to);
            n_cmp++;
            if (p !== exp_p) begin n_fail++; $display("[TB] FAIL random_product s=%0d q=%h m=%h got=%h exp=%h", s, q, m, p, exp_p); end
            n_cmp++;
            if (lat !== 8) begin n_fail++; $display("[TB] FAIL random_latency got=%0d exp=8", lat); end
`ifdef ROBMUL_FIT_FLAG_EN
            n_cmp++;
            if (fits !== ref_fits(s, val, 8)) begin n_fail++; $display("[TB] FAIL random_fits s=%0d q=%h m=%h got=%b exp=%b", s, q, m, fits, ref_fits(s, val, 8)); end
`endif
            if (($urandom % 2) == 0) idle_cycle();
        end
    endtask

    // A start while busy is ignored and nothing is queued.
    task automatic test_busy_ignore();
        int lat, dones;
        idle_cycle();
        signed_mode = 1'b1; multiplier = 8'd5; multiplicand = 8'd6; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        repeat (3) begin @(posedge clk); #1; lat++; end
        signed_mode = 1'b0; multiplier = 8'h7F; multiplicand = 8'h7F; start = 1'b1;
        @(posedge clk); #1; lat++;
        start = 1'b0;
        while (!done && lat < 40) begin @(posedge clk); #1; lat++; end
        n_cmp++;
        if (lat !== 8) begin n_fail++; $display("[TB] FAIL busy_ignore_latency got=%0d exp=8", lat); end
        n_cmp++;
        if (product !== 16'h001E) begin n_fail++; $display("[TB] FAIL busy_ignore_product got=%h exp=001e", product); end
        dones = 0;
        repeat (12) begin @(posedge clk); #1; if (done || busy) dones++; end
        n_cmp++;
        if (dones !== 0) begin n_fail++; $display("[TB] FAIL busy_ignore_no_queue active_cycles=%0d exp=0", dones); end
    endtask

    // Start in the DONE cycle launches the next operation immediately.
    task automatic test_back_to_back();
        logic [15:0] p;
        logic [15:0] exp1, exp2;
        longint v;
        int lat, bc, gap;
        bit to;
        logic [7:0] q1, m1, q2, m2;
        q1 = 8'($urandom); m1 = 8'($urandom);
        q2 = 8'($urandom); m2 = 8'($urandom);
        v = ref_value(1'b1, longint'(q1), longint'(m1), 8); exp1 = v[15:0];
        v = ref_value(1'b0, longint'(q2), longint'(m2), 8); exp2 = v[15:0];
        run_op(1'b1, q1, m1, p, lat, bc, to);
        n_cmp++;
        if (p !== exp1) begin n_fail++; $display("[TB] FAIL b2b_first got=%h exp=%h", p, exp1); end
        signed_mode = 1'b0; multiplier = q2; multiplicand = m2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        gap = 1;
        while (!done && gap < 40) begin @(posedge clk); #1; gap++; end
        n_cmp++;
        if (gap !== 9) begin n_fail++; $display("[TB] FAIL b2b_gap got=%0d exp=9", gap); end
        n_cmp++;
        if (product !== exp2) begin n_fail++; $display("[TB] FAIL b2b_second got=%h exp=%h", product, exp2); end
        idle_cycle();
    endtask

    // Reset mid-run aborts without a done pulse; the unit recovers.
    task automatic test_reset_mid();
        logic [15:0] p;
        int lat, bc, dones;
        bit to;
        signed_mode = 1'b1; multiplier = 8'd100; multiplicand = 8'hFD; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_busy got=%b exp=0", busy); end
        n_cmp++;
        if (product !== 16'h0000) begin n_fail++; $display("[TB] FAIL midreset_product got=%h exp=0000", product); end
        dones = 0;
        repeat (12) begin if (done) dones++; @(posedge clk); #1; end
        n_cmp++;
        if (dones !== 0) begin n_fail++; $display("[TB] FAIL midreset_no_done pulses=%0d exp=0", dones); end
        run_op(1'b1, 8'd3, 8'd3, p, lat, bc, to);
        n_cmp++;
        if (p !== 16'h0009) begin n_fail++; $display("[TB] FAIL midreset_recover got=%h exp=0009", p); end
        idle_cycle();
    endtask

    // 16-bit instance: directed case plus random operands.
    task automatic test_wide();
        logic [31:0] exp_p;
        longint v;
        int lat;
        bit s;
        logic [15:0] q, m;
        for (int i = 0; i < 6; i++) begin
            if (i == 0) begin
                s = 1'b1; q = 16'd300; m = 16'hFF38;
            end else begin
                s = 1'($urandom); q = 16'($urandom); m = 16'($urandom);
            end
            v = ref_value(s, longint'(q), longint'(m), 16);
            exp_p = v[31:0];
            signed_mode_w = s; multiplier_w = q; multiplicand_w = m; start_w = 1'b1;
            @(posedge clk); #1;
            start_w = 1'b0;
            lat = 0;
            while (!done_w && lat < 60) begin @(posedge clk); #1; lat++; end
            n_cmp++;
            if (lat !== 16) begin n_fail++; $display("[TB] FAIL wide_latency got=%0d exp=16", lat); end
            n_cmp++;
            if (product_w !== exp_p) begin n_fail++; $display("[TB] FAIL wide_product s=%0d q=%h m=%h got=%h exp=%h", s, q, m, product_w, exp_p); end
`ifdef ROBMUL_FIT_FLAG_EN
            n_cmp++;
            if (fits_w !== ref_fits(s, v, 16)) begin n_fail++; $display("[TB] FAIL wide_fits got=%b exp=%b", fits_w, ref_fits(s, v, 16)); end
`endif
            idle_cycle();
        end
        n_cmp++;
        if (32'hFFFF_15A0 !== 32'(ref_value(1'b1, 300, 65336, 16)) || product_w === 32'hx) begin
            n_fail++; $display("[TB] FAIL wide_reference got=%h exp=ffff15a0", 32'(ref_value(1'b1, 300, 65336, 16)));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; signed_mode = 1'b0;
        multiplier = '0; multiplicand = '0;
        start_w = 1'b0; signed_mode_w = 1'b0;
        multiplier_w = '0; multiplicand_w = '0;
        test_reset();
        test_directed();
`ifdef ROBMUL_FIT_FLAG_EN
        test_fits();
`endif
        test_random();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
